// File: rtl/pmem_pkg.sv
// Shared types and constants for the line memory responder.
//   pmem_state_t     : responder FSM states (idle, counting latency, completion pulse)
//   LINE_BYTES       : bytes per cache line
//   LINE_OFFSET_BITS : byte-offset bits ignored in the line address
//   line_t           : one 256-bit cache line
package pmem_pkg;

  typedef enum logic [1:0] {
    PM_IDLE = 2'd0,
    PM_BUSY = 2'd1,
    PM_RESP = 2'd2
  } pmem_state_t;

  localparam int LINE_BYTES       = 32;
  localparam int LINE_OFFSET_BITS = $clog2(LINE_BYTES);

  typedef logic [255:0] line_t;

endpackage

// File: rtl/line_ram.sv
// Single-port line array with a synchronous write and a registered read.
//   clk   : clock
//   we    : write enable, wdata stored at addr on the rising edge
//   re    : read enable, mem[addr] registered into rdata on the rising edge
//   addr  : line index
//   wdata : line to store
//   rdata : last line read, held while re is low
module line_ram #(
  parameter int WIDTH     = 256,
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset; a reset branch here
  // would stop block RAM inference and turn the array into flip-flops.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/line_memory_responder.sv
// Physical-memory responder for the L2 eviction-buffer line port.
// Each accepted request completes after a fixed latency with a one-cycle resp.
//   clk            : clock, all state on posedge
//   reset_n        : asynchronous active-low reset
//   read / write   : line request, held by the initiator until resp
//   address        : byte address, low offset bits ignored, high bits alias
//   wdata          : write line data
//   resp           : one-cycle completion pulse
//   rdata          : line from the most recent read, held until the next read resp
//   protocol_error : sticky flag for initiator protocol violations
module line_memory_responder
  import pmem_pkg::*;
#(
  parameter int LINE_WIDTH    = 256,
  parameter int DEPTH_LINES   = 1024,
  parameter int READ_LATENCY  = 8,
  parameter int WRITE_LATENCY = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           address,
  input  logic [LINE_WIDTH-1:0] wdata,
  output logic                  resp,
  output logic [LINE_WIDTH-1:0] rdata,
  output logic                  protocol_error
);

  localparam int         INDEX_BITS = $clog2(DEPTH_LINES);
  localparam int         TAG_BITS   = 32 - LINE_OFFSET_BITS;
  localparam logic [7:0] RD_LOAD    = 8'(READ_LATENCY - 1);
  localparam logic [7:0] WR_LOAD    = 8'(WRITE_LATENCY - 1);

  pmem_state_t           state_q, state_d;
  logic [7:0]            cnt_q, cnt_d, load;
  logic                  op_write_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  perr_q;
  logic                  rdata_valid_q;
  logic                  enter_resp;

  logic                  idle, accept_write, cur_write, perr_set;
  logic [INDEX_BITS-1:0] cur_index;
  logic [LINE_WIDTH-1:0] cur_wdata, ram_q;
  logic                  unused_offset;

  assign unused_offset = ^address[LINE_OFFSET_BITS-1:0];

  assign idle         = (state_q == PM_IDLE);
  // Both requests high is accepted as a read.
  assign accept_write = write & ~read;
  assign load         = accept_write ? WR_LOAD : RD_LOAD;

  // A latency of one enters RESP straight from IDLE, so the array must then
  // see the live request rather than the latch that is loading on that edge.
  assign cur_write = idle ? accept_write : op_write_q;
  assign cur_index = idle ? address[LINE_OFFSET_BITS +: INDEX_BITS]
                          : tag_q[INDEX_BITS-1:0];
  assign cur_wdata = idle ? wdata : wdata_q;

  // Violations: both requests in IDLE, or the latched request dropping or the
  // line address moving while the transaction is in flight.
  assign perr_set = (idle && read && write) ||
                    ((state_q == PM_BUSY) &&
                     ((op_write_q ? !write : !read) ||
                      (address[31:LINE_OFFSET_BITS] != tag_q)));

  // NOTE: every output of this block gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      PM_IDLE: begin
        if (read || write) begin
          if (load == 8'd0) begin
            state_d    = PM_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = PM_BUSY;
            cnt_d   = load;
          end
        end
      end
      PM_BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d    = PM_RESP;
          enter_resp = 1'b1;
        end
      end
      PM_RESP: state_d = PM_IDLE;
      default: state_d = PM_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= PM_IDLE;
      cnt_q         <= '0;
      op_write_q    <= 1'b0;
      tag_q         <= '0;
      wdata_q       <= '0;
      perr_q        <= 1'b0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && (read || write)) begin
        op_write_q <= accept_write;
        tag_q      <= address[31:LINE_OFFSET_BITS];
        wdata_q    <= wdata;
      end
      if (perr_set) perr_q <= 1'b1;
      if (enter_resp && !cur_write) rdata_valid_q <= 1'b1;
    end
  end

  line_ram #(
    .WIDTH     (LINE_WIDTH),
    .DEPTH     (DEPTH_LINES),
    .ADDR_BITS (INDEX_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (enter_resp & cur_write),
    .re    (enter_resp & ~cur_write),
    .addr  (cur_index),
    .wdata (cur_wdata),
    .rdata (ram_q)
  );

  // The RAM read register has no reset; gating it gives rdata its reset value
  // until the first read completes. It only reloads on read completions.
  assign rdata          = rdata_valid_q ? ram_q : '0;
  assign resp           = (state_q == PM_RESP);
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_line_memory_responder.sv
// Self-checking bench for line_memory_responder: directed vector table,
// mid-transaction reset sequence, randomized traffic against a line model,
// and an address-change violation sequence.
module tb_line_memory_responder;
  import pmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        read;
  logic        write;
  logic [31:0] address;
  line_t       wdata;
  logic        resp;
  line_t       rdata;
  logic        protocol_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_memory_responder #(
    .LINE_WIDTH    (256),
    .DEPTH_LINES   (1024),
    .READ_LATENCY  (8),
    .WRITE_LATENCY (6)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .read           (read),
    .write          (write),
    .address        (address),
    .wdata          (wdata),
    .resp           (resp),
    .rdata          (rdata),
    .protocol_error (protocol_error)
  );

  typedef struct {
    string       name;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    line_t       data;
    int          dkind;     // 0 none, 1 drop request, 2 move line address
    int          dcycle;    // cycle after acceptance where the disturbance lands
    int          exp_lat;
    line_t       exp_rdata;
    bit          exp_perr;
  } vec_t;

  // Behavioural line store: index = (byte address / 32) mod 1024.
  line_t mem_model [int];
  int    written [$];

  task automatic check(input string name, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One complete request: drive, measure cycles from acceptance to resp,
  // check resp width, rdata and the error flag.
  task automatic run_txn(input string name, input bit rd, input bit wr,
                         input logic [31:0] addr, input line_t data,
                         input int dkind, input int dcycle, input int exp_lat,
                         input line_t exp_rdata, input bit exp_perr);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    read = rd; write = wr; address = addr; wdata = data;
    @(posedge clk);  // acceptance edge
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (resp) begin
        lat = k;
        break;
      end
      if (dkind != 0 && k == dcycle) begin
        if (dkind == 1) begin
          read = 1'b0; write = 1'b0;
        end else begin
          address = address ^ 32'h0000_0020;
        end
      end
    end
    check({name, "_latency"}, line_t'(lat), line_t'(exp_lat));
    check({name, "_rdata"}, rdata, exp_rdata);
    check({name, "_perr"}, line_t'(protocol_error), line_t'(exp_perr));
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    check({name, "_pulse_width"}, line_t'(resp), '0);
    check({name, "_rdata_hold"}, rdata, exp_rdata);
  endtask

  function automatic line_t rand_line();
    line_t d;
    for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    line_t       p_aa, p_1234, exp_rd, d;
    logic [31:0] a;
    int          idx;
    bit          resp_seen;
    vec_t        vecs [6];

    p_aa   = {32{8'hAA}};
    p_1234 = {8{32'h1234_5678}};

    vecs[0] = '{"wr_aa",        1'b0, 1'b1, 32'h0000_0040, p_aa,          0, 0, 6, '0,     1'b0};
    vecs[1] = '{"rd_offset",    1'b1, 1'b0, 32'h0000_005C, '0,            0, 0, 8, p_aa,   1'b0};
    vecs[2] = '{"wr_alias",     1'b0, 1'b1, 32'h0000_8040, p_1234,        0, 0, 6, p_aa,   1'b0};
    vecs[3] = '{"rd_alias",     1'b1, 1'b0, 32'h0000_0040, '0,            0, 0, 8, p_1234, 1'b0};
    vecs[4] = '{"rd_wr_both",   1'b1, 1'b1, 32'h0000_0040, {32{8'h55}},   0, 0, 8, p_1234, 1'b1};
    vecs[5] = '{"drop_read",    1'b1, 1'b0, 32'h0000_005C, '0,            1, 3, 8, p_1234, 1'b1};

    reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_resp", line_t'(resp), '0);
    check("reset_rdata", rdata, '0);
    check("reset_perr", line_t'(protocol_error), '0);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
              vecs[i].dkind, vecs[i].dcycle, vecs[i].exp_lat,
              vecs[i].exp_rdata, vecs[i].exp_perr);

    // Reset four cycles into a write: no resp, rdata cleared, write never lands.
    @(posedge clk); #1;
    write = 1'b1; address = 32'h0000_0040; wdata = ~p_1234;
    @(posedge clk);
    repeat (4) @(negedge clk);
    reset_n = 1'b0; write = 1'b0;
    #1;
    check("abort_rst_resp", line_t'(resp), '0);
    check("abort_rst_rdata", rdata, '0);
    check("abort_rst_perr", line_t'(protocol_error), '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    resp_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (resp) resp_seen = 1'b1;
    end
    check("abort_no_resp", line_t'(resp_seen), '0);
    run_txn("reread_after_reset", 1'b1, 1'b0, 32'h0000_0040, '0, 0, 0, 8, p_1234, 1'b0);

    // Randomized traffic against the line model.
    mem_model[2] = p_1234;
    written.push_back(2);
    exp_rd = p_1234;
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        a   = $urandom();
        d   = rand_line();
        idx = int'((a >> 5) % 1024);
        run_txn("rand_write", 1'b0, 1'b1, a, d, 0, 0, 6, exp_rd, 1'b0);
        if (!mem_model.exists(idx)) written.push_back(idx);
        mem_model[idx] = d;
      end else begin
        idx = written[$urandom_range(0, written.size() - 1)];
        a   = ($urandom_range(0, 131071) << 15) | (idx << 5) | $urandom_range(0, 31);
        exp_rd = mem_model[idx];
        run_txn("rand_read", 1'b1, 1'b0, a, rand_line(), 0, 0, 8, exp_rd, 1'b0);
      end
    end

    // Line address moves mid-write: error flagged, latched line still written.
    d = rand_line();
    run_txn("addr_change_wr", 1'b0, 1'b1, 32'h0000_0060, d, 2, 2, 6, exp_rd, 1'b1);
    mem_model[3] = d;
    exp_rd = mem_model[3];
    run_txn("addr_change_rd3", 1'b1, 1'b0, 32'h0000_0060, '0, 0, 0, 8, exp_rd, 1'b1);
    exp_rd = mem_model[2];
    run_txn("addr_change_rd2", 1'b1, 1'b0, 32'h0000_0040, '0, 0, 0, 8, exp_rd, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
